// File: rtl/rtc_ctrl_pkg.sv
// Shared types and constants for the RTC time controller.
// RTC_ALARM_EN widens the mode encoding to cover the alarm set states.
package rtc_ctrl_pkg;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int CNT_W   = 6;

`ifdef RTC_ALARM_EN
    localparam int MODE_W  = 3;
`else
    localparam int MODE_W  = 2;
`endif

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with load. wrap_o is a combinational carry so that
// chained counters resolve a full rollover in a single clock.
module mod_counter #(
    parameter int             MOD     = 60,
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o,
    output logic         wrap_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        wrap_o  = inc_i && (value_q == W'(MOD - 1));
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = wrap_o ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/rtc_time_controller.sv
// Time-of-day controller with RUN/SET mode FSM, advanced by a 1 Hz tick.
// Define RTC_ALARM_EN to add the alarm registers, alarm set states and alarm_active.
module rtc_time_controller
    import rtc_ctrl_pkg::*;
#(
    parameter int HOURS_MOD     = 24,
    parameter int RESET_HOURS   = 0,
    parameter int RESET_MINUTES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [MODE_W-1:0] mode,
    output logic              blink,
    output logic              alarm_active
);

    state_e state_q, state_d;
    logic   blink_q, blink_d;
    logic   time_run;
    logic   sec_inc, min_inc, hr_inc, sec_load;
    logic   sec_wrap, min_wrap, hr_wrap;

    always_comb begin
        state_d = state_q;
        if (btn_mode) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
`ifdef RTC_ALARM_EN
                SET_M:   state_d = SET_AH;
                SET_AH:  state_d = SET_AM;
                SET_AM:  state_d = RUN;
`else
                SET_M:   state_d = RUN;
`endif
                default: state_d = RUN;
            endcase
        end
    end

    // Blink restarts high on entering any set state, then toggles once per tick.
    always_comb begin
        blink_d = blink_q;
        if (state_d == RUN) begin
            blink_d = 1'b0;
        end else if (state_d != state_q) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
        end
    end

`ifdef RTC_ALARM_EN
    assign time_run = (state_q == RUN) || (state_q == SET_AH) || (state_q == SET_AM);
`else
    assign time_run = (state_q == RUN);
`endif

    assign sec_inc  = time_run && tick_1hz;
    assign min_inc  = (time_run && sec_wrap) || ((state_q == SET_M) && btn_inc);
    assign hr_inc   = (time_run && min_wrap) || ((state_q == SET_H) && btn_inc);
    assign sec_load = (state_q == SET_M) && btn_mode;

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W), .RST_VAL('0)) u_sec (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sec_load),
        .load_val_i ('0),
        .inc_i      (sec_inc),
        .value_o    (seconds),
        .wrap_o     (sec_wrap)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MIN_W), .RST_VAL(MIN_W'(RESET_MINUTES))) u_min (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (min_inc),
        .value_o    (minutes),
        .wrap_o     (min_wrap)
    );

    mod_counter #(.MOD(HOURS_MOD), .W(HOUR_W), .RST_VAL(HOUR_W'(RESET_HOURS))) u_hr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (hr_inc),
        .value_o    (hours),
        .wrap_o     (hr_wrap)
    );

    assign mode  = state_q[MODE_W-1:0];
    assign blink = blink_q;

`ifdef RTC_ALARM_EN
    logic [HOUR_W-1:0] alarm_hours;
    logic [MIN_W-1:0]  alarm_minutes;
    logic [HOUR_W-1:0] hr_next;
    logic [MIN_W-1:0]  min_next;
    logic              ah_wrap, am_wrap;
    logic              alarm_hit;
    logic              alarm_q, alarm_d;
    logic [CNT_W-1:0]  alarm_cnt_q, alarm_cnt_d;

    mod_counter #(.MOD(HOURS_MOD), .W(HOUR_W), .RST_VAL('0)) u_alarm_hr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      ((state_q == SET_AH) && btn_inc),
        .value_o    (alarm_hours),
        .wrap_o     (ah_wrap)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MIN_W), .RST_VAL('0)) u_alarm_min (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      ((state_q == SET_AM) && btn_inc),
        .value_o    (alarm_minutes),
        .wrap_o     (am_wrap)
    );

    // Only meaningful when sec_wrap is high: the hh:mm the clock rolls into.
    assign min_next  = min_wrap ? '0 : minutes + 1'b1;
    assign hr_next   = min_wrap ? (hr_wrap ? '0 : hours + 1'b1) : hours;
    assign alarm_hit = (state_q == RUN) && sec_wrap &&
                       (min_next == alarm_minutes) && (hr_next == alarm_hours);

    always_comb begin
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if ((state_q == RUN) && btn_inc) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = '0;
        end else if (alarm_q && tick_1hz) begin
            if (alarm_cnt_q == CNT_W'(59)) begin
                alarm_d = 1'b0;
            end else begin
                alarm_cnt_d = alarm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    logic unused_alarm_wraps;
    assign unused_alarm_wraps = ah_wrap ^ am_wrap;
    assign alarm_active = alarm_q;
`else
    logic unused_hr_wrap;
    assign unused_hr_wrap = hr_wrap;
    assign alarm_active   = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_time_controller.sv
// Directed bench for rtc_time_controller: reset, carry chain, set modes,
// simultaneous events, and the alarm when RTC_ALARM_EN is defined.
module tb_rtc_time_controller;
    import rtc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic btn_m = 1'b0;
    logic btn_i = 1'b0;

    logic [HOUR_W-1:0] a_h, b_h, c_h;
    logic [MIN_W-1:0]  a_m, b_m, c_m;
    logic [SEC_W-1:0]  a_s, b_s, c_s;
    logic [MODE_W-1:0] a_mode, b_mode, c_mode;
    logic              a_blink, b_blink, c_blink;
    logic              a_alarm, b_alarm, c_alarm;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    rtc_time_controller #(.HOURS_MOD(24), .RESET_HOURS(7), .RESET_MINUTES(30)) u_a (
        .clk(clk), .rst(rst), .tick_1hz(tick), .btn_mode(btn_m), .btn_inc(btn_i),
        .hours(a_h), .minutes(a_m), .seconds(a_s), .mode(a_mode), .blink(a_blink),
        .alarm_active(a_alarm)
    );

    rtc_time_controller #(.HOURS_MOD(24), .RESET_HOURS(23), .RESET_MINUTES(59)) u_b (
        .clk(clk), .rst(rst), .tick_1hz(tick), .btn_mode(btn_m), .btn_inc(btn_i),
        .hours(b_h), .minutes(b_m), .seconds(b_s), .mode(b_mode), .blink(b_blink),
        .alarm_active(b_alarm)
    );

    rtc_time_controller #(.HOURS_MOD(12), .RESET_HOURS(11), .RESET_MINUTES(59)) u_c (
        .clk(clk), .rst(rst), .tick_1hz(tick), .btn_mode(btn_m), .btn_inc(btn_i),
        .hours(c_h), .minutes(c_m), .seconds(c_s), .mode(c_mode), .blink(c_blink),
        .alarm_active(c_alarm)
    );

`ifdef RTC_ALARM_EN
    logic [HOUR_W-1:0] d_h;
    logic [MIN_W-1:0]  d_m;
    logic [SEC_W-1:0]  d_s;
    logic [MODE_W-1:0] d_mode;
    logic              d_blink, d_alarm;

    rtc_time_controller #(.HOURS_MOD(24), .RESET_HOURS(5), .RESET_MINUTES(59)) u_d (
        .clk(clk), .rst(rst), .tick_1hz(tick), .btn_mode(btn_m), .btn_inc(btn_i),
        .hours(d_h), .minutes(d_m), .seconds(d_s), .mode(d_mode), .blink(d_blink),
        .alarm_active(d_alarm)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given pulses; outputs are stable on return.
    task automatic pulse(input logic t, input logic m, input logic i);
        tick  = t;
        btn_m = m;
        btn_i = i;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        btn_m = 1'b0;
        btn_i = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) pulse(1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset_all();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_a(input string tag, input int h, input int m, input int s);
        check({tag, ".h"}, 32'(a_h), 32'(h));
        check({tag, ".m"}, 32'(a_m), 32'(m));
        check({tag, ".s"}, 32'(a_s), 32'(s));
    endtask

    initial begin
        // Reset state of all instances.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_a("rst_a", 7, 30, 0);
        check("rst_a.mode", 32'(a_mode), 32'd0);
        check("rst_a.blink", 32'(a_blink), 32'd0);
        check("rst_a.alarm", 32'(a_alarm), 32'd0);
        check("rst_b.h", 32'(b_h), 32'd23);
        check("rst_c.h", 32'(c_h), 32'd11);
        rst = 1'b1;

        pulse(1'b0, 1'b0, 1'b0);
        check("idle.s", 32'(a_s), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            ticks(1);
            check("run.s", 32'(a_s), 32'(k));
        end

        // Carry chain on B (24 h) and C (12 h).
        ticks(55);
        check("b58.h", 32'(b_h), 32'd23);
        check("b58.m", 32'(b_m), 32'd59);
        check("b58.s", 32'(b_s), 32'd58);
        ticks(1);
        check("b59.s", 32'(b_s), 32'd59);
        check("c59.h", 32'(c_h), 32'd11);
        check("c59.s", 32'(c_s), 32'd59);
        ticks(1);
        check("bwrap.h", 32'(b_h), 32'd0);
        check("bwrap.m", 32'(b_m), 32'd0);
        check("bwrap.s", 32'(b_s), 32'd0);
        check("cwrap.h", 32'(c_h), 32'd0);
        check("cwrap.m", 32'(c_m), 32'd0);
        check("cwrap.s", 32'(c_s), 32'd0);
        chk_a("amin", 7, 31, 0);

        // Reset wins over a simultaneous tick.
        rst  = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        rst  = 1'b1;
        chk_a("midrst", 7, 30, 0);
        check("midrst.mode", 32'(a_mode), 32'd0);

        // SET_H: time frozen, hours edited, blink toggles from 1.
        ticks(3);
        pulse(1'b0, 1'b1, 1'b0);
        check("seth.mode", 32'(a_mode), 32'd1);
        check("seth.blink", 32'(a_blink), 32'd1);
        incs(3);
        check("seth.h", 32'(a_h), 32'd10);
        for (int k = 0; k < 5; k++) begin
            ticks(1);
            check("seth.blink_t", 32'(a_blink), 32'(k % 2 == 0 ? 0 : 1));
        end
        chk_a("frozen", 10, 30, 3);
        incs(13);
        check("seth.h23", 32'(a_h), 32'd23);
        incs(1);
        chk_a("hwrap", 0, 30, 3);

        // SET_M: minute wrap without carry, seconds cleared on exit.
        pulse(1'b0, 1'b1, 1'b0);
        check("setm.mode", 32'(a_mode), 32'd2);
        check("setm.blink", 32'(a_blink), 32'd1);
        incs(28);
        check("setm.m58", 32'(a_m), 32'd58);
        incs(3);
        chk_a("mwrap", 0, 1, 3);
        ticks(1);
        check("setm.frz_s", 32'(a_s), 32'd3);
        check("setm.blink_t", 32'(a_blink), 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        check("setm.exit_s", 32'(a_s), 32'd0);
`ifdef RTC_ALARM_EN
        check("setah.mode", 32'(a_mode), 32'd3);
        pulse(1'b0, 1'b1, 1'b0);
        check("setam.mode", 32'(a_mode), 32'd4);
        pulse(1'b0, 1'b1, 1'b0);
`endif
        check("run.mode", 32'(a_mode), 32'd0);
        check("run.blink", 32'(a_blink), 32'd0);
        chk_a("run", 0, 1, 0);
        incs(2);
        chk_a("run_inc_ign", 0, 1, 0);

        // Simultaneous tick+mode in RUN, inc+mode in SET_H.
        ticks(5);
        pulse(1'b1, 1'b1, 1'b0);
        check("tm.s", 32'(a_s), 32'd6);
        check("tm.mode", 32'(a_mode), 32'd1);
        check("tm.blink", 32'(a_blink), 32'd1);
        pulse(1'b0, 1'b1, 1'b1);
        check("im.h", 32'(a_h), 32'd1);
        check("im.mode", 32'(a_mode), 32'd2);
        check("im.blink", 32'(a_blink), 32'd1);
        check("im.m", 32'(a_m), 32'd1);
        check("alarm_off", 32'(a_alarm), 32'd0);

`ifdef RTC_ALARM_EN
        // Alarm at 06:00 on instance D (reset 05:59:00).
        for (int run = 0; run < 2; run++) begin
            reset_all();
            pulse(1'b0, 1'b1, 1'b0);
            pulse(1'b0, 1'b1, 1'b0);
            pulse(1'b0, 1'b1, 1'b0);
            check("al.setah", 32'(d_mode), 32'd3);
            incs(6);
            pulse(1'b0, 1'b1, 1'b0);
            pulse(1'b0, 1'b1, 1'b0);
            check("al.run", 32'(d_mode), 32'd0);
            check("al.h", 32'(d_h), 32'd5);
            check("al.m", 32'(d_m), 32'd59);
            ticks(59);
            check("al.pre_s", 32'(d_s), 32'd59);
            check("al.pre", 32'(d_alarm), 32'd0);
            ticks(1);
            check("al.hit_h", 32'(d_h), 32'd6);
            check("al.hit_m", 32'(d_m), 32'd0);
            check("al.hit", 32'(d_alarm), 32'd1);
            if (run == 0) begin
                ticks(59);
                check("al.59", 32'(d_alarm), 32'd1);
                ticks(1);
                check("al.60", 32'(d_alarm), 32'd0);
            end else begin
                ticks(10);
                check("al.10", 32'(d_alarm), 32'd1);
                pulse(1'b0, 1'b0, 1'b1);
                check("al.inc_clr", 32'(d_alarm), 32'd0);
                check("al.inc_s", 32'(d_s), 32'd10);
                check("al.inc_m", 32'(d_m), 32'd0);
                check("al.inc_mode", 32'(d_mode), 32'd0);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
